// File: rtl/cmp_serial_front.sv
// Serial MSB-first operand loader for the W-bit magnitude comparator, plus
// result capture register, saturating outcome tallies and a sticky flag check.
module cmp_serial_front #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sdi_a,
    input  logic             sdi_b,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic             flag_err,
    input  logic             clr_cnt,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and in_ready depends on state only.

    localparam int BC_W = (W > 2) ? $clog2(W) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic             r_res_valid;
    logic             r_res_gt;
    logic             r_res_lt;
    logic             r_res_eq;
    logic [CNT_W-1:0] r_cnt_gt;
    logic [CNT_W-1:0] r_cnt_lt;
    logic [CNT_W-1:0] r_cnt_eq;
    logic             r_flag_err;
    logic             w_shift;
    logic             w_sample;
    logic             w_onehot;

    assign w_shift  = (r_state == LOAD) && in_valid;
    assign w_sample = (r_state == SAMPLE);
    assign w_onehot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                      ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                      ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (in_valid && (r_bit_cnt == LAST_BIT)) w_next = SAMPLE;
            SAMPLE:  w_next = HOLD;
            HOLD:    if (r_res_valid && res_ready) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
        end else if (w_shift) begin
            r_op_a    <= {r_op_a[W-2:0], sdi_a};
            r_op_b    <= {r_op_b[W-2:0], sdi_b};
            r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_gt    <= 1'b0;
            r_res_lt    <= 1'b0;
            r_res_eq    <= 1'b0;
        end else if (w_sample) begin
            r_res_valid <= 1'b1;
            r_res_gt    <= cmp_gt;
            r_res_lt    <= cmp_lt;
            r_res_eq    <= cmp_eq;
        end else if ((r_state == HOLD) && r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Clear has priority over a coincident tally increment or error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_gt   <= '0;
            r_cnt_lt   <= '0;
            r_cnt_eq   <= '0;
            r_flag_err <= 1'b0;
        end else if (clr_cnt) begin
            r_cnt_gt   <= '0;
            r_cnt_lt   <= '0;
            r_cnt_eq   <= '0;
            r_flag_err <= 1'b0;
        end else if (w_sample) begin
            if (!w_onehot)                       r_flag_err <= 1'b1;
            else if (cmp_gt && r_cnt_gt != CNT_MAX) r_cnt_gt <= r_cnt_gt + 1'b1;
            else if (cmp_lt && r_cnt_lt != CNT_MAX) r_cnt_lt <= r_cnt_lt + 1'b1;
            else if (cmp_eq && r_cnt_eq != CNT_MAX) r_cnt_eq <= r_cnt_eq + 1'b1;
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign res_valid = r_res_valid;
    assign res_gt    = r_res_gt;
    assign res_lt    = r_res_lt;
    assign res_eq    = r_res_eq;
    assign cnt_gt    = r_cnt_gt;
    assign cnt_lt    = r_cnt_lt;
    assign cnt_eq    = r_cnt_eq;
    assign flag_err  = r_flag_err;
    assign dbg_state = r_state;

endmodule
